// File: rtl/fio_stream_buffer_pkg.sv
// Shared constants for the fio stream buffer.
//   FIO_BYTE_W     : width of one stream byte
//   FIO_EMPTY_BYTE : value shown on fio_din while the RX FIFO holds nothing
package fio_stream_buffer_pkg;
   localparam int FIO_BYTE_W = 8;
   localparam logic [FIO_BYTE_W-1:0] FIO_EMPTY_BYTE = 8'hff;
endpackage

// File: rtl/fio_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO.
//   mclk, puc_rst : clock, synchronous active-high reset
//   push, din     : write din this cycle (caller guarantees !full or a same-cycle pop)
//   full          : occupancy == 2**AW
//   pop, dout     : dout is the head byte; pop advances it (caller guarantees !empty)
//   empty         : occupancy == 0
//   level         : registered occupancy 0..2**AW
module fio_byte_fifo
   import fio_stream_buffer_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic                  mclk,
   input  logic                  puc_rst,
   input  logic                  push,
   input  logic [FIO_BYTE_W-1:0] din,
   output logic                  full,
   input  logic                  pop,
   output logic [FIO_BYTE_W-1:0] dout,
   output logic                  empty,
   output logic [AW:0]           level
);
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [FIO_BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;

   // Storage carries no reset; stale bytes are unreachable once the pointers clear.
   always_ff @(posedge mclk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // When full, wr_ptr == rd_ptr: a push+pop overwrites the slot being read,
   // which is safe because the head is sampled before the edge.
   assign dout  = mem[rd_ptr];
   assign full  = (level == FULL_CNT);
   assign empty = (level == '0);
endmodule

// File: rtl/fio_stream_buffer.sv
// Byte buffering between the host harness and the file I/O peripheral stream pins.
//   RX: host_rx_* push -> fio_din/fio_dready head, popped by fio_dnxt
//   TX: fio_dout/fio_dout_rdy push -> host_tx_data/host_tx_valid head, popped by host_tx_ready
//   rx_level/tx_level : registered occupancies
//   rx_unf/tx_ovf     : sticky error flags, cleared by err_clr (a new error wins)
module fio_stream_buffer
   import fio_stream_buffer_pkg::*;
#(
   parameter int RX_AW = 4,
   parameter int TX_AW = 4
) (
   input  logic                  mclk,
   input  logic                  puc_rst,
   input  logic [FIO_BYTE_W-1:0] host_rx_data,
   input  logic                  host_rx_valid,
   output logic                  host_rx_ready,
   output logic [FIO_BYTE_W-1:0] fio_din,
   output logic                  fio_dready,
   input  logic                  fio_dnxt,
   input  logic [FIO_BYTE_W-1:0] fio_dout,
   input  logic                  fio_dout_rdy,
   output logic [FIO_BYTE_W-1:0] host_tx_data,
   output logic                  host_tx_valid,
   input  logic                  host_tx_ready,
   output logic [RX_AW:0]        rx_level,
   output logic [TX_AW:0]        tx_level,
   output logic                  rx_unf,
   output logic                  tx_ovf,
   input  logic                  err_clr
);
   logic                  rx_full, rx_empty, rx_push, rx_pop;
   logic                  tx_full, tx_empty, tx_push, tx_pop;
   logic [FIO_BYTE_W-1:0] rx_head;
   logic                  rx_unf_set, tx_ovf_set;

   // RX never accepts into a full FIFO, even with a same-cycle pop, so
   // host_rx_ready depends on registered state only.
   assign rx_push    = host_rx_valid & ~rx_full;
   assign rx_pop     = fio_dnxt & ~rx_empty;
   assign rx_unf_set = fio_dnxt & rx_empty;

   // TX accepts into a full FIFO when the harness drains in the same cycle.
   assign tx_pop     = host_tx_ready & ~tx_empty;
   assign tx_push    = fio_dout_rdy & (~tx_full | tx_pop);
   assign tx_ovf_set = fio_dout_rdy & tx_full & ~host_tx_ready;

   fio_byte_fifo #(.AW(RX_AW)) u_rx_fifo (
      .mclk    (mclk),
      .puc_rst (puc_rst),
      .push    (rx_push),
      .din     (host_rx_data),
      .full    (rx_full),
      .pop     (rx_pop),
      .dout    (rx_head),
      .empty   (rx_empty),
      .level   (rx_level)
   );

   fio_byte_fifo #(.AW(TX_AW)) u_tx_fifo (
      .mclk    (mclk),
      .puc_rst (puc_rst),
      .push    (tx_push),
      .din     (fio_dout),
      .full    (tx_full),
      .pop     (tx_pop),
      .dout    (host_tx_data),
      .empty   (tx_empty),
      .level   (tx_level)
   );

   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         rx_unf <= 1'b0;
         tx_ovf <= 1'b0;
      end else begin
         if (rx_unf_set)   rx_unf <= 1'b1;
         else if (err_clr) rx_unf <= 1'b0;
         if (tx_ovf_set)   tx_ovf <= 1'b1;
         else if (err_clr) tx_ovf <= 1'b0;
      end
   end

   assign host_rx_ready = ~rx_full;
   assign fio_dready    = ~rx_empty;
   assign fio_din       = rx_empty ? FIO_EMPTY_BYTE : rx_head;
   assign host_tx_valid = ~tx_empty;
endmodule

// File: tb/tb_fio_stream_buffer.sv
// Randomized plus directed bench for fio_stream_buffer. A negedge monitor keeps
// reference queues of the RX/TX contents, compares every presented head and
// every consumed byte, and then applies the cycle's transfers to the queues.
module tb_fio_stream_buffer;
   logic       mclk = 1'b0;
   logic       puc_rst;
   logic [7:0] host_rx_data;
   logic       host_rx_valid;
   logic       host_rx_ready;
   logic [7:0] fio_din;
   logic       fio_dready;
   logic       fio_dnxt;
   logic [7:0] fio_dout;
   logic       fio_dout_rdy;
   logic [7:0] host_tx_data;
   logic       host_tx_valid;
   logic       host_tx_ready;
   logic [4:0] rx_level;
   logic [4:0] tx_level;
   logic       rx_unf;
   logic       tx_ovf;
   logic       err_clr;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   bit         unf_m = 1'b0;
   bit         ovf_m = 1'b0;

   fio_stream_buffer #(.RX_AW(4), .TX_AW(4)) dut (
      .mclk          (mclk),
      .puc_rst       (puc_rst),
      .host_rx_data  (host_rx_data),
      .host_rx_valid (host_rx_valid),
      .host_rx_ready (host_rx_ready),
      .fio_din       (fio_din),
      .fio_dready    (fio_dready),
      .fio_dnxt      (fio_dnxt),
      .fio_dout      (fio_dout),
      .fio_dout_rdy  (fio_dout_rdy),
      .host_tx_data  (host_tx_data),
      .host_tx_valid (host_tx_valid),
      .host_tx_ready (host_tx_ready),
      .rx_level      (rx_level),
      .tx_level      (tx_level),
      .rx_unf        (rx_unf),
      .tx_ovf        (tx_ovf),
      .err_clr       (err_clr)
   );

   always #5 mclk = ~mclk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Monitor / scoreboard: inputs are driven just after posedge, so at negedge
   // both inputs and outputs are stable for the coming edge.
   always @(negedge mclk) begin
      if (mon_en) begin
         int rx_n, tx_n;
         bit rx_pop_m, tx_pop_m;
         logic [7:0] exp;
         rx_n = rx_q.size();
         tx_n = tx_q.size();
         chk("rx_level", rx_level, rx_n);
         chk("tx_level", tx_level, tx_n);
         chk("host_rx_ready", host_rx_ready, rx_n < 16);
         chk("fio_dready", fio_dready, rx_n > 0);
         chk("host_tx_valid", host_tx_valid, tx_n > 0);
         chk("rx_unf", rx_unf, unf_m);
         chk("tx_ovf", tx_ovf, ovf_m);
         if (rx_n == 0) chk("fio_din_empty", fio_din, 8'hff);
         if (puc_rst) begin
            rx_q.delete();
            tx_q.delete();
            unf_m = 1'b0;
            ovf_m = 1'b0;
         end else begin
            rx_pop_m = fio_dnxt && rx_n > 0;
            if (rx_pop_m) begin
               exp = rx_q.pop_front();
               chk("rx_pop_data", fio_din, exp);
            end
            if (host_rx_valid && rx_n < 16) rx_q.push_back(host_rx_data);
            tx_pop_m = host_tx_ready && tx_n > 0;
            if (tx_pop_m) begin
               exp = tx_q.pop_front();
               chk("tx_pop_data", host_tx_data, exp);
            end
            if (fio_dout_rdy && (tx_n < 16 || tx_pop_m)) tx_q.push_back(fio_dout);
            if (fio_dnxt && rx_n == 0) unf_m = 1'b1;
            else if (err_clr) unf_m = 1'b0;
            if (fio_dout_rdy && tx_n == 16 && !host_tx_ready) ovf_m = 1'b1;
            else if (err_clr) ovf_m = 1'b0;
         end
      end
   end

   task automatic cyc();
      @(posedge mclk);
      #1;
   endtask

   task automatic idle();
      host_rx_valid = 1'b0;
      fio_dnxt      = 1'b0;
      fio_dout_rdy  = 1'b0;
      host_tx_ready = 1'b0;
      err_clr       = 1'b0;
      puc_rst       = 1'b0;
   endtask

   initial begin
      idle();
      host_rx_data = 8'h00;
      fio_dout     = 8'h00;
      puc_rst      = 1'b1;
      cyc();
      mon_en = 1'b1;
      cyc();
      puc_rst = 1'b0;
      chk("reset_rx_level", rx_level, 0);
      chk("reset_din", fio_din, 8'hff);
      chk("reset_rx_ready", host_rx_ready, 1);

      // RX ordering
      foreach (rx_q[i]) ;
      for (int i = 0; i < 3; i++) begin
         host_rx_valid = 1'b1;
         host_rx_data  = 8'h41 + 8'(i);
         cyc();
      end
      host_rx_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rx_order", fio_din, 8'h41 + 8'(i));
         fio_dnxt = 1'b1;
         cyc();
      end
      fio_dnxt = 1'b0;
      chk("rx_order_dready", fio_dready, 0);
      chk("rx_order_din", fio_din, 8'hff);

      // RX full: 17th byte held by the host until space opens
      host_rx_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         host_rx_data = 8'h60 + 8'(i);
         cyc();
      end
      chk("rx_full_ready", host_rx_ready, 0);
      chk("rx_full_level", rx_level, 16);
      host_rx_data = 8'h70;
      cyc();
      chk("rx_full_hold", rx_level, 16);
      fio_dnxt = 1'b1;
      cyc();
      chk("rx_full_pushpop", rx_level, 15);
      fio_dnxt = 1'b0;
      cyc();
      chk("rx_17th_accepted", rx_level, 16);
      host_rx_valid = 1'b0;
      fio_dnxt = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("rx_17th_last", fio_din, 8'h70);
         cyc();
      end
      fio_dnxt = 1'b0;
      chk("rx_drained", rx_level, 0);

      // TX overflow
      fio_dout_rdy = 1'b1;
      for (int i = 0; i < 17; i++) begin
         fio_dout = 8'h20 + 8'(i);
         cyc();
      end
      fio_dout_rdy = 1'b0;
      chk("tx_ovf_level", tx_level, 16);
      chk("tx_ovf_flag", tx_ovf, 1);
      host_tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("tx_drain_order", host_tx_data, 8'h20 + 8'(i));
         cyc();
      end
      host_tx_ready = 1'b0;
      chk("tx_drained_valid", host_tx_valid, 0);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("tx_ovf_clr", tx_ovf, 0);

      // TX full with simultaneous push and pop
      fio_dout_rdy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         fio_dout = 8'h80 + 8'(i);
         cyc();
      end
      fio_dout = 8'h5a;
      host_tx_ready = 1'b1;
      cyc();
      fio_dout_rdy = 1'b0;
      host_tx_ready = 1'b0;
      chk("tx_simul_level", tx_level, 16);
      chk("tx_simul_noovf", tx_ovf, 0);
      host_tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("tx_5a_last", host_tx_data, 8'h5a);
         cyc();
      end
      host_tx_ready = 1'b0;

      // Underflow and flag priority
      fio_dnxt = 1'b1;
      cyc();
      fio_dnxt = 1'b0;
      chk("unf_set", rx_unf, 1);
      chk("unf_level", rx_level, 0);
      err_clr = 1'b1;
      cyc();
      chk("unf_clr", rx_unf, 0);
      fio_dnxt = 1'b1;
      cyc();
      chk("unf_set_wins", rx_unf, 1);
      fio_dnxt = 1'b0;
      cyc();
      err_clr = 1'b0;
      host_rx_valid = 1'b1;
      host_rx_data  = 8'h33;
      fio_dnxt      = 1'b1;
      cyc();
      idle();
      chk("empty_pushpop_level", rx_level, 1);
      chk("empty_pushpop_din", fio_din, 8'h33);
      chk("empty_pushpop_unf", rx_unf, 1);
      fio_dnxt = 1'b1;
      err_clr  = 1'b1;
      cyc();
      idle();

      // Wrap: 40 bytes through RX with random pops
      begin
         int sent = 0;
         for (int c = 0; c < 400 && (sent < 40 || rx_level != 0); c++) begin
            host_rx_valid = (sent < 40);
            host_rx_data  = 8'h90 + 8'(sent);
            fio_dnxt      = 1'($urandom_range(0, 1)) & fio_dready;
            if (host_rx_valid && host_rx_ready) sent++;
            cyc();
         end
         idle();
         chk("wrap_sent", sent, 40);
         chk("wrap_empty", rx_level, 0);
      end

      // Randomized traffic with periodic mid-traffic resets
      for (int c = 0; c < 3000; c++) begin
         int bias;
         bias = (c / 250) % 3;
         host_rx_data  = 8'($urandom);
         fio_dout      = 8'($urandom);
         host_rx_valid = ($urandom_range(0, 3) < 1 + bias);
         fio_dnxt      = ($urandom_range(0, 3) < 3 - bias);
         fio_dout_rdy  = ($urandom_range(0, 3) < 1 + bias);
         host_tx_ready = ($urandom_range(0, 3) < 3 - bias);
         err_clr       = ($urandom_range(0, 15) == 0);
         puc_rst       = 1'b0;
         if (c % 700 == 699) begin
            puc_rst = 1'b1;
            cyc();
            cyc();
            idle();
            chk("mid_rst_rx_level", rx_level, 0);
            chk("mid_rst_tx_level", tx_level, 0);
            chk("mid_rst_dready", fio_dready, 0);
            chk("mid_rst_din", fio_din, 8'hff);
            chk("mid_rst_flags", {rx_unf, tx_ovf}, 0);
         end
         cyc();
      end
      idle();
      cyc();
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
